// File: rtl/exe_stage_if.sv
// Data SRAM request bus driven by the EXE stage.
// Signals: data_sram_en, data_sram_we[3:0], data_sram_addr[31:0], data_sram_wdata[31:0].
interface exe_stage_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  modport master (
    output data_sram_en,
    output data_sram_we,
    output data_sram_addr,
    output data_sram_wdata
  );

  modport slave (
    input data_sram_en,
    input data_sram_we,
    input data_sram_addr,
    input data_sram_wdata
  );
endinterface

// File: rtl/exe_stage.sv
// EXE pipeline stage: ALU, optional 3-cycle mul.w (EXE_MUL_EN), data SRAM request.
// Ports: clk/reset, ID->EXE handshake + fields, MEM handshake, forwarding/stall, sram bus.
module exe_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_to_es_valid,
  input  logic        ds_ready_go,
  output logic        es_allow_in,
  input  logic [31:0] ds_pc,
  input  logic [31:0] ds_alu_src1,
  input  logic [31:0] ds_alu_src2,
  input  logic [31:0] ds_st_data,
  input  logic [11:0] ds_alu_op,
  input  logic        ds_mul,
  input  logic        ds_sram_en,
  input  logic [3:0]  ds_sram_we,
  input  logic [3:0]  ds_rf_we,
  input  logic [4:0]  ds_rf_waddr,
  input  logic [4:0]  ds_rf_raddr1,
  input  logic [4:0]  ds_rf_raddr2,
  input  logic        ms_allow_in,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic [31:0] es_result,
  output logic        es_res_from_mem,
  output logic [3:0]  es_rf_we,
  output logic [4:0]  es_rf_waddr,
  output logic [31:0] es_rf_wdata,
  output logic        es_load_stall,
  exe_stage_if.master sram
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_src1;
  logic [31:0] r_src2;
  logic [31:0] r_st_data;
  logic [11:0] r_alu_op;
  logic        r_sram_en;
  logic [3:0]  r_sram_we;
  logic [3:0]  r_rf_we;
  logic [4:0]  r_rf_waddr;

  logic        w_ready_go;
  logic        w_latch;
  logic [31:0] w_alu;
  logic [4:0]  w_sh;

  assign w_latch = ds_ready_go & es_allow_in;

  // A new latch takes priority over the handoff clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_pc       <= 32'h1c000000;
      r_src1     <= '0;
      r_src2     <= '0;
      r_st_data  <= '0;
      r_alu_op   <= '0;
      r_sram_en  <= 1'b0;
      r_sram_we  <= '0;
      r_rf_we    <= '0;
      r_rf_waddr <= '0;
    end else if (w_latch) begin
      r_valid    <= ds_to_es_valid;
      r_pc       <= ds_pc;
      r_src1     <= ds_alu_src1;
      r_src2     <= ds_alu_src2;
      r_st_data  <= ds_st_data;
      r_alu_op   <= ds_alu_op;
      r_sram_en  <= ds_sram_en;
      r_sram_we  <= ds_sram_we;
      r_rf_we    <= ds_rf_we;
      r_rf_waddr <= ds_rf_waddr;
    end else if (r_valid & w_ready_go & ms_allow_in) begin
      r_valid    <= 1'b0;
    end
  end

  assign w_sh = r_src2[4:0];

  always_comb begin
    w_alu = '0;
    case (1'b1)
      r_alu_op[0]:  w_alu = r_src1 + r_src2;
      r_alu_op[1]:  w_alu = r_src1 - r_src2;
      r_alu_op[2]:  w_alu = {31'b0, $signed(r_src1) < $signed(r_src2)};
      r_alu_op[3]:  w_alu = {31'b0, r_src1 < r_src2};
      r_alu_op[4]:  w_alu = r_src1 & r_src2;
      r_alu_op[5]:  w_alu = ~(r_src1 | r_src2);
      r_alu_op[6]:  w_alu = r_src1 | r_src2;
      r_alu_op[7]:  w_alu = r_src1 ^ r_src2;
      r_alu_op[8]:  w_alu = r_src1 << w_sh;
      r_alu_op[9]:  w_alu = r_src1 >> w_sh;
      r_alu_op[10]: w_alu = $unsigned($signed(r_src1) >>> w_sh);
      r_alu_op[11]: w_alu = r_src2;
      default:      w_alu = '0;
    endcase
  end

`ifdef EXE_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mstate_t;

  mstate_t     r_state;
  logic        r_mul;
  logic        r_cnt;
  logic [31:0] r_prod;
  logic [31:0] w_prod;

  assign w_prod = r_src1 * r_src2;

  // Two BUSY cycles (cnt 1 then 0); product is captured entering DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mul   <= 1'b0;
      r_cnt   <= 1'b0;
      r_prod  <= '0;
    end else begin
      if (w_latch)
        r_mul <= ds_mul;
      case (r_state)
        S_IDLE: begin
          if (r_valid & r_mul) begin
            r_state <= S_BUSY;
            r_cnt   <= 1'b1;
          end
        end
        S_BUSY: begin
          if (r_cnt == 1'b0) begin
            r_state <= S_DONE;
            r_prod  <= w_prod;
          end else begin
            r_cnt <= 1'b0;
          end
        end
        S_DONE: begin
          if (ms_allow_in)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_ready_go = !r_mul | (r_state == S_DONE);
  assign es_result  = r_mul ? r_prod : w_alu;
`else
  logic w_unused_mul;
  assign w_unused_mul = ds_mul;
  assign w_ready_go   = 1'b1;
  assign es_result    = w_alu;
`endif

  assign es_allow_in     = !r_valid | (w_ready_go & ms_allow_in);
  assign es_to_ms_valid  = r_valid & w_ready_go;
  assign es_pc           = r_pc;
  assign es_res_from_mem = r_sram_en;
  assign es_rf_we        = r_valid ? r_rf_we : 4'b0;
  assign es_rf_waddr     = r_rf_waddr;
  assign es_rf_wdata     = es_result;

  assign es_load_stall = r_valid & r_sram_en & (r_rf_waddr != 5'd0)
                       & ((r_rf_waddr == ds_rf_raddr1)
                        | (r_rf_waddr == ds_rf_raddr2));

  assign sram.data_sram_en    = r_valid & (r_sram_en | (|r_sram_we));
  assign sram.data_sram_we    = r_valid ? r_sram_we : 4'b0;
  assign sram.data_sram_addr  = es_result;
  assign sram.data_sram_wdata = r_st_data;

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: directed cases, then random traffic
// checked by a scoreboard against a behavioural model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_to_es_valid, ds_ready_go, es_allow_in;
  logic [31:0] ds_pc, ds_alu_src1, ds_alu_src2, ds_st_data;
  logic [11:0] ds_alu_op;
  logic        ds_mul, ds_sram_en;
  logic [3:0]  ds_sram_we, ds_rf_we;
  logic [4:0]  ds_rf_waddr, ds_rf_raddr1, ds_rf_raddr2;
  logic        ms_allow_in, es_to_ms_valid;
  logic [31:0] es_pc, es_result, es_rf_wdata;
  logic        es_res_from_mem, es_load_stall;
  logic [3:0]  es_rf_we;
  logic [4:0]  es_rf_waddr;

  exe_stage_if sif ();

  exe_stage dut (
    .clk(clk), .reset(reset),
    .ds_to_es_valid(ds_to_es_valid), .ds_ready_go(ds_ready_go),
    .es_allow_in(es_allow_in),
    .ds_pc(ds_pc), .ds_alu_src1(ds_alu_src1), .ds_alu_src2(ds_alu_src2),
    .ds_st_data(ds_st_data), .ds_alu_op(ds_alu_op), .ds_mul(ds_mul),
    .ds_sram_en(ds_sram_en), .ds_sram_we(ds_sram_we), .ds_rf_we(ds_rf_we),
    .ds_rf_waddr(ds_rf_waddr), .ds_rf_raddr1(ds_rf_raddr1),
    .ds_rf_raddr2(ds_rf_raddr2), .ms_allow_in(ms_allow_in),
    .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc), .es_result(es_result),
    .es_res_from_mem(es_res_from_mem), .es_rf_we(es_rf_we),
    .es_rf_waddr(es_rf_waddr), .es_rf_wdata(es_rf_wdata),
    .es_load_stall(es_load_stall), .sram(sif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, res, st;
    logic [3:0]  swe, rfwe;
    logic        sen, mul;
    logic [4:0]  wa;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  int   age = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference ALU written with plain integer arithmetic.
  function automatic logic [31:0] ref_alu(int op, logic [31:0] a,
                                          logic [31:0] b);
    longint ua, sa, sb, p;
    int n;
    ua = longint'({32'b0, a});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b % 32);
    p  = longint'(1) << n;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return (sa < sb) ? 32'd1 : 32'd0;
      3:  return (ua < longint'({32'b0, b})) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return 32'(ua * p);
      9:  return 32'(ua / p);
      10: return a[31] ? 32'((ua / p) | ~(32'hFFFFFFFF >> n))
                       : 32'(ua / p);
      default: return b;
    endcase
  endfunction

  // Scoreboard monitor: queue front is the instruction held in EXE.
  always @(negedge clk) begin
    if (mon_en && reset == 1'b0) begin
      if (q.size() == 0) begin
        chk("idle_tmv", 32'(es_to_ms_valid), 32'd0);
        chk("idle_sen", 32'(sif.data_sram_en), 32'd0);
        chk("idle_rfwe", 32'(es_rf_we), 32'd0);
        chk("idle_stall", 32'(es_load_stall), 32'd0);
        chk("idle_allow", 32'(es_allow_in), 32'd1);
        age = 0;
      end else begin
        exp_t f;
        bit rdy, st;
        f = q[0];
`ifdef EXE_MUL_EN
        rdy = f.mul ? (age >= 3) : 1'b1;
`else
        rdy = 1'b1;
`endif
        st = f.sen && f.wa != 0 &&
             (f.wa == ds_rf_raddr1 || f.wa == ds_rf_raddr2);
        chk("tmv", 32'(es_to_ms_valid), 32'(rdy));
        chk("allow", 32'(es_allow_in), 32'(rdy && ms_allow_in));
        chk("stall", 32'(es_load_stall), 32'(st));
        chk("sram_en", 32'(sif.data_sram_en),
            32'(f.sen || f.swe != 0));
        chk("sram_we", 32'(sif.data_sram_we), 32'(f.swe));
        chk("sram_wd", sif.data_sram_wdata, f.st);
        chk("rf_we", 32'(es_rf_we), 32'(f.rfwe));
        if (rdy) begin
          chk("result", es_result, f.res);
          chk("rf_wdata", es_rf_wdata, f.res);
          chk("sram_addr", sif.data_sram_addr, f.res);
          chk("pc", es_pc, f.pc);
          chk("waddr", 32'(es_rf_waddr), 32'(f.wa));
          chk("from_mem", 32'(es_res_from_mem), 32'(f.sen));
        end
        if (rdy && ms_allow_in) begin
          void'(q.pop_front());
          age = 0;
        end else begin
          age++;
        end
      end
    end
  end

  task automatic send(int op, logic [31:0] a, logic [31:0] b,
                      logic sen, logic [3:0] swe, logic [4:0] wa,
                      logic mul);
    ds_alu_op      = 12'd1 << op;
    ds_alu_src1    = a;
    ds_alu_src2    = b;
    ds_sram_en     = sen;
    ds_sram_we     = swe;
    ds_rf_waddr    = wa;
    ds_mul         = mul;
    ds_rf_we       = sen ? 4'hF : 4'h0;
    ds_pc          = ds_pc + 32'd4;
    ds_to_es_valid = 1'b1;
    ds_ready_go    = 1'b1;
    @(posedge clk);
    #1 ds_to_es_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    reset = 1'b1;
    ds_to_es_valid = 0; ds_ready_go = 0; ds_pc = 32'h1c000000;
    ds_alu_src1 = 0; ds_alu_src2 = 0; ds_st_data = 0; ds_alu_op = 0;
    ds_mul = 0; ds_sram_en = 0; ds_sram_we = 0; ds_rf_we = 0;
    ds_rf_waddr = 0; ds_rf_raddr1 = 0; ds_rf_raddr2 = 0;
    ms_allow_in = 1'b1;
    #12;
    chk("rst_allow", 32'(es_allow_in), 32'd1);
    chk("rst_tmv", 32'(es_to_ms_valid), 32'd0);
    chk("rst_sen", 32'(sif.data_sram_en), 32'd0);
    chk("rst_swe", 32'(sif.data_sram_we), 32'd0);
    chk("rst_rfwe", 32'(es_rf_we), 32'd0);
    chk("rst_stall", 32'(es_load_stall), 32'd0);
    chk("rst_pc", es_pc, 32'h1c000000);
    @(negedge clk);
    reset = 1'b0;

    send(0, 32'd5, 32'd7, 1'b0, 4'h0, 5'd1, 1'b0);
    @(negedge clk);
    chk("add_res", es_result, 32'd12);
    chk("add_tmv", 32'(es_to_ms_valid), 32'd1);
    send(10, 32'h80000000, 32'd4, 1'b0, 4'h0, 5'd2, 1'b0);
    @(negedge clk);
    chk("sra_res", es_result, 32'hF8000000);
    send(3, 32'd1, 32'hFFFFFFFF, 1'b0, 4'h0, 5'd2, 1'b0);
    @(negedge clk);
    chk("sltu_res", es_result, 32'd1);
    send(2, 32'd1, 32'hFFFFFFFF, 1'b0, 4'h0, 5'd2, 1'b0);
    @(negedge clk);
    chk("slt_res", es_result, 32'd0);

    send(0, 32'd100, 32'd4, 1'b1, 4'h0, 5'd3, 1'b0);
    ms_allow_in = 1'b0;
    ds_rf_raddr1 = 5'd0;
    ds_rf_raddr2 = 5'd3;
    @(negedge clk);
    chk("ld_stall", 32'(es_load_stall), 32'd1);
    ds_rf_raddr2 = 5'd7;
    #1 chk("ld_nostall", 32'(es_load_stall), 32'd0);
    ms_allow_in = 1'b1;
    ds_rf_raddr2 = 5'd0;
    send(0, 32'd100, 32'd4, 1'b1, 4'h0, 5'd0, 1'b0);
    @(negedge clk);
    chk("ld0_stall", 32'(es_load_stall), 32'd0);

    ds_st_data = 32'hDEADBEEF;
    send(0, 32'h1000, 32'd8, 1'b0, 4'hF, 5'd0, 1'b0);
    ms_allow_in = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("st_allow", 32'(es_allow_in), 32'd0);
      chk("st_tmv", 32'(es_to_ms_valid), 32'd1);
      chk("st_en", 32'(sif.data_sram_en), 32'd1);
      chk("st_we", 32'(sif.data_sram_we), 32'hF);
      chk("st_addr", sif.data_sram_addr, 32'h1008);
      chk("st_wd", sif.data_sram_wdata, 32'hDEADBEEF);
    end
    ms_allow_in = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("st_done", 32'(sif.data_sram_en), 32'd0);

`ifdef EXE_MUL_EN
    send(0, 32'h10000, 32'h10000, 1'b0, 4'h0, 5'd4, 1'b1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (es_to_ms_valid) break;
      cnt++;
    end
    chk("mul_lat", 32'(cnt), 32'd3);
    chk("mul_res", es_result, 32'd0);
    @(posedge clk);
    #1;
    send(0, 32'd3, 32'd5, 1'b0, 4'h0, 5'd4, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mrst_tmv", 32'(es_to_ms_valid), 32'd0);
    chk("mrst_allow", 32'(es_allow_in), 32'd1);
    @(negedge clk);
    reset = 1'b0;
`else
    cnt = 0;
`endif

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      exp_t e;
      bit lat;
      int op;
      op = int'($urandom_range(0, 11));
      ds_alu_op      = 12'd1 << op;
      ds_alu_src1    = $urandom;
      ds_alu_src2    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40)
                                                   : $urandom;
      ds_st_data     = $urandom;
      ds_pc          = $urandom;
      ds_mul         = ($urandom_range(0, 5) == 0);
      ds_sram_en     = !ds_mul && ($urandom_range(0, 3) == 0);
      ds_sram_we     = (!ds_mul && !ds_sram_en &&
                        $urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      ds_rf_we       = 4'($urandom);
      ds_rf_waddr    = 5'($urandom_range(0, 7));
      ds_rf_raddr1   = 5'($urandom_range(0, 7));
      ds_rf_raddr2   = 5'($urandom_range(0, 7));
      ds_to_es_valid = ($urandom_range(0, 9) < 7);
      ds_ready_go    = ($urandom_range(0, 9) < 8);
      ms_allow_in    = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      lat = ds_ready_go && es_allow_in && ds_to_es_valid;
      e.pc = ds_pc; e.st = ds_st_data; e.swe = ds_sram_we;
      e.rfwe = ds_rf_we; e.sen = ds_sram_en; e.wa = ds_rf_waddr;
`ifdef EXE_MUL_EN
      e.mul = ds_mul;
      e.res = ds_mul ? ds_alu_src1 * ds_alu_src2
                     : ref_alu(op, ds_alu_src1, ds_alu_src2);
`else
      e.mul = 1'b0;
      e.res = ref_alu(op, ds_alu_src1, ds_alu_src2);
`endif
      @(posedge clk);
      if (lat) q.push_back(e);
      #1;
    end
    ds_to_es_valid = 1'b0;
    ms_allow_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", 32'(q.size()), 32'd0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
